// File: rtl/abs_diff_eval_pkg.sv
// Shared types and helpers for the abs_diff evaluation harness.
//   state_e  : sweep controller states
//   ABS_W    : working width of the absolute-difference helper
//   abs_diff : unsigned |a - b|; callers zero-extend operands into ABS_W bits
//              and cast the result back to their own width.
package abs_diff_eval_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SWEEP = 3'd1,
        DRAIN = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int ABS_W = 16;

    // One extra bit on the difference carries the sign of a - b.
    function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                  input logic [ABS_W-1:0] b);
        logic [ABS_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[ABS_W]) begin
            abs_diff = b - a;
        end else begin
            abs_diff = diff[ABS_W-1:0];
        end
    endfunction

endpackage

// File: rtl/abs_diff_valid_pipe.sv
// Delays the stimulus-valid bit by DUT_LAT cycles so it lines up with the
// responses of a DUT that has DUT_LAT cycles of latency.
//   clk, rst : clock, asynchronous active-high reset (flushes the line)
//   valid_i  : valid bit launched with the stimulus
//   valid_o  : valid bit aligned to the DUT responses
// DUT_LAT = 0 is a plain combinational pass-through.
module abs_diff_valid_pipe #(
    parameter int DUT_LAT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    output logic valid_o
);

    generate
        if (DUT_LAT == 0) begin : g_bypass
            assign valid_o = valid_i;
        end else begin : g_shift
            logic [DUT_LAT-1:0] shift_q;

            // Shift the valid bit one stage per cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shift_q <= '0;
                end else begin
                    shift_q[0] <= valid_i;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        shift_q[i] <= shift_q[i-1];
                    end
                end
            end

            assign valid_o = shift_q[DUT_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/abs_diff_err_monitor.sv
// Exhaustive evaluation harness for an approximate abs_diff circuit.
// Sweeps every input vector 0 .. 2^IN_W-1 into an exact and an approximate
// DUT, compares their responses and reports worst-case error, the number of
// vectors whose error exceeds ET, and a pass flag.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a sweep (only honoured in IDLE or DONE)
//   stim       : vector driven to both DUTs
//   stim_valid : stim is a live sweep vector
//   exact_in   : exact DUT response
//   approx_in  : approximate DUT response
//   busy       : high in SWEEP and DRAIN
//   done       : level, high in DONE
//   max_err    : largest |exact - approx| this sweep
//   viol_cnt   : number of vectors with error > ET
//   pass       : viol_cnt == 0, meaningful while done is high
//   err_sum    : sum of all errors; only built when ABS_DIFF_ERR_SUM_EN is
//                defined, otherwise tied to zero
module abs_diff_err_monitor
    import abs_diff_eval_pkg::*;
#(
    parameter int IN_W    = 4,
    parameter int OUT_W   = 3,
    parameter int ET      = 2,
    parameter int DUT_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [IN_W-1:0]       stim,
    output logic                  stim_valid,
    input  logic [OUT_W-1:0]      exact_in,
    input  logic [OUT_W-1:0]      approx_in,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_W-1:0]      max_err,
    output logic [IN_W:0]         viol_cnt,
    output logic                  pass,
    output logic [IN_W+OUT_W-1:0] err_sum
);

    localparam int NUM_VEC = 2**IN_W;
    // Counter is one bit wider than stim so the terminal value never wraps.
    localparam logic [IN_W:0] LAST_VEC   = (IN_W+1)'(NUM_VEC - 1);
    // Only reachable when DUT_LAT > 0.
    localparam logic [2:0]    DRAIN_LAST = 3'(DUT_LAT - 1);

    state_e          state_q;
    logic [IN_W:0]   stim_cnt_q;
    logic [2:0]      drain_cnt_q;
    logic            stim_valid_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [OUT_W-1:0] max_err_q;
    logic [OUT_W-1:0] max_err_d;
    logic [IN_W:0]   viol_cnt_q;
    logic [IN_W:0]   viol_cnt_d;
    logic [OUT_W-1:0] err_s;
    logic            rsp_valid_s;
    logic            start_ok_s;

    abs_diff_valid_pipe #(
        .DUT_LAT(DUT_LAT)
    ) u_valid_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (stim_valid_q),
        .valid_o (rsp_valid_s)
    );

    assign start_ok_s = start && ((state_q == IDLE) || (state_q == DONE));
    assign err_s      = OUT_W'(abs_diff(ABS_W'(exact_in), ABS_W'(approx_in)));

    // Next statistic values for an aligned response.
    always_comb begin
        max_err_d  = max_err_q;
        viol_cnt_d = viol_cnt_q;
        if (rsp_valid_s) begin
            if (err_s > max_err_q) begin
                max_err_d = err_s;
            end else begin
                max_err_d = max_err_q;
            end
            if (32'(err_s) > ET) begin
                viol_cnt_d = viol_cnt_q + (IN_W+1)'(1);
            end else begin
                viol_cnt_d = viol_cnt_q;
            end
        end else begin
            max_err_d  = max_err_q;
            viol_cnt_d = viol_cnt_q;
        end
    end

    // Sweep controller, statistic registers and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            stim_cnt_q   <= '0;
            drain_cnt_q  <= 3'd0;
            stim_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            max_err_q    <= '0;
            viol_cnt_q   <= '0;
        end else begin
            max_err_q  <= max_err_d;
            viol_cnt_q <= viol_cnt_d;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= SWEEP;
                        stim_cnt_q   <= '0;
                        stim_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        max_err_q    <= '0;
                        viol_cnt_q   <= '0;
                    end
                end
                SWEEP: begin
                    if (stim_cnt_q == LAST_VEC) begin
                        stim_valid_q <= 1'b0;
                        drain_cnt_q  <= 3'd0;
                        if (DUT_LAT > 0) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q <= CHECK;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        stim_cnt_q <= stim_cnt_q + (IN_W+1)'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q <= CHECK;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 3'd1;
                    end
                end
                CHECK: begin
                    // Last response was absorbed on the edge into CHECK.
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    pass_q  <= (viol_cnt_q == '0);
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ABS_DIFF_ERR_SUM_EN
    logic [IN_W+OUT_W-1:0] err_sum_q;

    // Error accumulator; wide enough for NUM_VEC maximal errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sum_q <= '0;
        end else if (start_ok_s) begin
            err_sum_q <= '0;
        end else if (rsp_valid_s) begin
            err_sum_q <= err_sum_q + (IN_W+OUT_W)'(err_s);
        end
    end

    assign err_sum = err_sum_q;
`else
    assign err_sum = '0;
`endif

    assign stim       = stim_cnt_q[IN_W-1:0];
    assign stim_valid = stim_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign max_err    = max_err_q;
    assign viol_cnt   = viol_cnt_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_abs_diff_err_monitor.sv
// Bench for abs_diff_err_monitor. Instance A: DUT_LAT=0, ET=2 with a
// combinational DUT model. Instance B: DUT_LAT=3, ET=6 with a registered
// 3-stage DUT model. Expected sweep results are pushed to a queue when a
// sweep is launched and popped when done rises.
module tb_abs_diff_err_monitor;

    typedef struct {
        int max_err;
        int viol;
        int pass;
        int sum;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    // Instance A signals
    logic       start_a = 1'b0;
    logic [3:0] stim_a;
    logic       sv_a;
    logic [2:0] ex_a;
    logic [2:0] ap_a;
    logic       busy_a;
    logic       done_a;
    logic [2:0] max_a;
    logic [4:0] viol_a;
    logic       pass_a;
    logic [6:0] sum_a;
    int         mode_a = 0;

    // Instance B signals
    logic       start_b = 1'b0;
    logic [3:0] stim_b;
    logic       sv_b;
    logic [2:0] ex_b1 = 3'd0;
    logic [2:0] ex_b2 = 3'd0;
    logic [2:0] ex_b3 = 3'd0;
    logic [2:0] ap_b;
    logic       busy_b;
    logic       done_b;
    logic [2:0] max_b;
    logic [4:0] viol_b;
    logic       pass_b;
    logic [6:0] sum_b;
    int         mode_b = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // Exact DUT: |a - b| with a = in[1:0], b = in[3:2].
    function automatic logic [2:0] exact_f(input logic [3:0] v);
        int a;
        int b;
        a = int'(v[1:0]);
        b = int'(v[3:2]);
        return (a >= b) ? 3'(a - b) : 3'(b - a);
    endfunction

    // Approximate DUT: 0 = exact, 1 = stuck at 0, 2 = exact xor 3'b111.
    function automatic logic [2:0] approx_f(input logic [2:0] e, input int mode);
        if (mode == 1) return 3'd0;
        if (mode == 2) return e ^ 3'b111;
        return e;
    endfunction

    function automatic exp_t model(input int mode, input int et, input int lat);
        exp_t r;
        r.max_err = 0;
        r.viol    = 0;
        r.sum     = 0;
        for (int v = 0; v < 16; v++) begin
            int e;
            int ap;
            int err;
            e   = int'(exact_f(4'(v)));
            ap  = int'(approx_f(3'(e), mode));
            err = (e >= ap) ? e - ap : ap - e;
            if (err > r.max_err) r.max_err = err;
            if (err > et) r.viol++;
            r.sum += err;
        end
        r.pass = (r.viol == 0) ? 1 : 0;
`ifndef ABS_DIFF_ERR_SUM_EN
        r.sum = 0;
`endif
        r.lat = 16 + lat + 1;
        return r;
    endfunction

    assign ex_a = exact_f(stim_a);
    assign ap_a = approx_f(ex_a, mode_a);
    assign ap_b = approx_f(ex_b3, mode_b);

    always @(posedge clk) begin
        ex_b1 <= exact_f(stim_b);
        ex_b2 <= ex_b1;
        ex_b3 <= ex_b2;
    end

    abs_diff_err_monitor #(.IN_W(4), .OUT_W(3), .ET(2), .DUT_LAT(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .stim_valid(sv_a),
        .exact_in(ex_a), .approx_in(ap_a), .busy(busy_a), .done(done_a),
        .max_err(max_a), .viol_cnt(viol_a), .pass(pass_a), .err_sum(sum_a)
    );

    abs_diff_err_monitor #(.IN_W(4), .OUT_W(3), .ET(6), .DUT_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stim(stim_b), .stim_valid(sv_b),
        .exact_in(ex_b3), .approx_in(ap_b), .busy(busy_b), .done(done_b),
        .max_err(max_b), .viol_cnt(viol_b), .pass(pass_b), .err_sum(sum_b)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Stimulus sequence monitors: stim must count 0,1,2.. while stim_valid.
    int exp_stim_a = 0;
    int exp_stim_b = 0;
    always @(negedge clk) begin
        if (rst || !sv_a) begin
            exp_stim_a = 0;
        end else begin
            check_val("stim_a", 32'(stim_a), 32'(exp_stim_a));
            exp_stim_a++;
        end
        if (rst || !sv_b) begin
            exp_stim_b = 0;
        end else begin
            check_val("stim_b", 32'(stim_b), 32'(exp_stim_b));
            exp_stim_b++;
        end
    end

    task automatic reset_checks(input string tag);
        check_val({tag, "_stim"},     32'(stim_a), 32'd0);
        check_val({tag, "_stim_vld"}, 32'(sv_a),   32'd0);
        check_val({tag, "_busy"},     32'(busy_a), 32'd0);
        check_val({tag, "_done"},     32'(done_a), 32'd0);
        check_val({tag, "_max_err"},  32'(max_a),  32'd0);
        check_val({tag, "_viol"},     32'(viol_a), 32'd0);
        check_val({tag, "_pass"},     32'(pass_a), 32'd0);
        check_val({tag, "_err_sum"},  32'(sum_a),  32'd0);
    endtask

    // Call at the negedge right after start was sampled.
    task automatic wait_done(input int inst, input bit pulse_mid);
        int   cyc;
        exp_t e;
        logic dn;
        cyc = 0;
        dn  = (inst == 0) ? done_a : done_b;
        while (!dn && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (pulse_mid && cyc == 5) start_a = 1'b1;
            if (pulse_mid && cyc == 6) start_a = 1'b0;
            dn = (inst == 0) ? done_a : done_b;
        end
        if (inst == 0) e = q_a.pop_front();
        else           e = q_b.pop_front();
        check_val("done_latency", 32'(cyc), 32'(e.lat));
        if (inst == 0) begin
            check_val("max_err_a", 32'(max_a),  32'(e.max_err));
            check_val("viol_a",    32'(viol_a), 32'(e.viol));
            check_val("pass_a",    32'(pass_a), 32'(e.pass));
            check_val("err_sum_a", 32'(sum_a),  32'(e.sum));
            check_val("busy_a",    32'(busy_a), 32'd0);
        end else begin
            check_val("max_err_b", 32'(max_b),  32'(e.max_err));
            check_val("viol_b",    32'(viol_b), 32'(e.viol));
            check_val("pass_b",    32'(pass_b), 32'(e.pass));
            check_val("err_sum_b", 32'(sum_b),  32'(e.sum));
            check_val("busy_b",    32'(busy_b), 32'd0);
        end
    endtask

    task automatic launch(input int inst, input int mode, input int et, input int lat);
        if (inst == 0) begin
            mode_a = mode;
            q_a.push_back(model(mode, et, lat));
            @(negedge clk);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end else begin
            mode_b = mode;
            q_b.push_back(model(mode, et, lat));
            @(negedge clk);
            start_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0;
        end
    endtask

    initial begin
        int cyc;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        reset_checks("rst");
        rst = 1'b0;
        @(negedge clk);
        reset_checks("idle");

        // Exact == approx, zero latency.
        launch(0, 0, 2, 0);
        wait_done(0, 1'b0);

        // Stuck-at-0 approx; a start pulse mid-sweep must be ignored.
        launch(0, 1, 2, 0);
        wait_done(0, 1'b1);

        // XOR approx against ET=2.
        launch(0, 2, 2, 0);
        wait_done(0, 1'b0);

        // Three-cycle DUT latency, exact == approx.
        launch(1, 0, 6, 3);
        wait_done(1, 1'b0);

        // Three-cycle latency, XOR approx against ET=6.
        launch(1, 2, 6, 3);
        wait_done(1, 1'b0);

        // Three-cycle latency, stuck-at-0: errors never exceed ET=6.
        launch(1, 1, 6, 3);
        wait_done(1, 1'b0);

        // Asynchronous reset in the middle of a sweep.
        mode_a = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 0;
        while (stim_a !== 4'd7 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_val("reach_stim7", 32'(stim_a), 32'd7);
        rst = 1'b1;
        #1;
        reset_checks("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        launch(0, 1, 2, 0);
        wait_done(0, 1'b0);

        // start held through DONE: back-to-back sweeps, fresh statistics.
        mode_a = 1;
        q_a.push_back(model(1, 2, 0));
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        wait_done(0, 1'b0);
        mode_a = 0;
        q_a.push_back(model(0, 2, 0));
        @(negedge clk);
        start_a = 1'b0;
        check_val("b2b_restart_vld", 32'(sv_a), 32'd1);
        wait_done(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
